// File: rtl/rv_pkg.sv
// Shared fetch-side definitions: branch funct3 encodings, fetch FSM states
// and the canonical NOP instruction.
package rv_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } pc_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/br_taken.sv
// Branch condition decoder: turns funct3 plus the comparator flags into a
// taken/not-taken decision. Undefined branch encodings are never taken.
module br_taken
    import rv_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       less,
    input  logic       equal,
    output logic       taken
);

    // Select the comparator flag (or its inverse) that the encoding asks for
    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = equal;
            F3_BNE:  taken = !equal;
            F3_BLT:  taken = less;
            F3_BLTU: taken = less;
            F3_BGE:  taken = !less;
            F3_BGEU: taken = !less;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_gen.sv
// Program counter generator: issues one instruction fetch at a time, holds
// the returned instruction until downstream consumes it, then steps to the
// next PC (sequential, branch/jump target, or trap vector when the target
// is not word aligned). Also counts retired instructions.
module pc_gen
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    input  logic        i_branch,
    input  logic        i_jump,
    input  logic [2:0]  i_funct3,
    input  logic        i_br_less,
    input  logic        i_br_equal,
    input  logic [31:0] i_target,
    output logic        o_br_un,
    output logic        o_misaligned,
    output logic [31:0] o_instret
);

    pc_state_e   state;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] candidate;
    logic        taken;
    logic        redirect;
    logic        target_misaligned;
    logic        accept;

    br_taken u_br_taken (
        .funct3 (i_funct3),
        .less   (i_br_less),
        .equal  (i_br_equal),
        .taken  (taken)
    );

    // Memory and downstream handshake outputs are decoded from the state
    always_comb begin
        o_imem_req    = (state == FETCH);
        o_imem_addr   = pc;
        o_pc          = pc;
        o_instr_valid = (state == HOLD);
        o_br_un       = i_funct3[1];
        accept        = (state == HOLD) && i_instr_ready;
    end

    // Next PC: jumps always redirect, branches only when taken; bit 0 of the
    // target is dropped and a target not on a word boundary traps instead
    always_comb begin
        redirect          = i_jump | (i_branch & taken);
        candidate         = i_target & ~32'h0000_0001;
        target_misaligned = redirect & candidate[1];
        if (target_misaligned) begin
            pc_next = TRAP_VEC;
        end else if (redirect) begin
            pc_next = candidate;
        end else begin
            pc_next = pc + 32'd4;
        end
    end

    // Fetch FSM plus PC, held instruction, retire counter and trap pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            o_instr      <= NOP;
            o_instret    <= 32'd0;
            o_misaligned <= 1'b0;
        end else begin
            o_misaligned <= 1'b0;
            case (state)
                FETCH: begin
                    if (i_imem_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (i_imem_rvalid) begin
                        o_instr <= i_imem_rdata;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (accept) begin
                        pc           <= pc_next;
                        o_instret    <= o_instret + 32'd1;
                        o_misaligned <= target_misaligned;
                        state        <= FETCH;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Testbench for pc_gen: directed scenarios followed by a randomized run,
// all checked against a behavioural model of fetch address and retire count.
module tb_pc_gen;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    logic        i_clk;
    logic        i_rst;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ready;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        o_instr_valid;
    logic        i_instr_ready;
    logic        i_branch;
    logic        i_jump;
    logic [2:0]  i_funct3;
    logic        i_br_less;
    logic        i_br_equal;
    logic [31:0] i_target;
    logic        o_br_un;
    logic        o_misaligned;
    logic [31:0] o_instret;

    int n_cmp;
    int n_fail;

    logic [31:0] m_pc;
    logic [31:0] m_instret;
    logic [31:0] m_instr;
    logic        m_mis;

    pc_gen #(
        .RESET_PC (RESET_PC),
        .TRAP_VEC (TRAP_VEC)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_ready  (i_imem_ready),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .o_instr       (o_instr),
        .o_pc          (o_pc),
        .o_instr_valid (o_instr_valid),
        .i_instr_ready (i_instr_ready),
        .i_branch      (i_branch),
        .i_jump        (i_jump),
        .i_funct3      (i_funct3),
        .i_br_less     (i_br_less),
        .i_br_equal    (i_br_equal),
        .i_target      (i_target),
        .o_br_un       (o_br_un),
        .o_misaligned  (o_misaligned),
        .o_instret     (o_instret)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Architectural next-PC rule: condition table, drop target bit 0,
    // trap when the resulting address is not a multiple of four
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic br, input logic jp,
                                               input logic [2:0] f3, input logic lt, input logic eq,
                                               input logic [31:0] tgt, output logic mis);
        logic        take;
        logic [31:0] cand;
        case (f3)
            3'd0:       take = eq;
            3'd1:       take = !eq;
            3'd4, 3'd6: take = lt;
            3'd5, 3'd7: take = !lt;
            default:    take = 1'b0;
        endcase
        cand = tgt - (tgt % 2);
        mis  = 1'b0;
        if (jp || (br && take)) begin
            if (cand % 4 == 2) begin
                mis = 1'b1;
                return TRAP_VEC;
            end
            return cand;
        end
        return pc + 32'd4;
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Drive one complete fetch from FETCH into HOLD
    task automatic do_fetch(input logic [31:0] data);
        i_imem_ready = 1'b1;
        step();
        i_imem_ready  = 1'b0;
        i_imem_rvalid = 1'b1;
        i_imem_rdata  = data;
        step();
        i_imem_rvalid = 1'b0;
        m_instr       = data;
    endtask

    // Consume the held instruction with the given resolution inputs
    task automatic do_accept(input logic br, input logic jp, input logic [2:0] f3,
                             input logic lt, input logic eq, input logic [31:0] tgt);
        i_branch      = br;
        i_jump        = jp;
        i_funct3      = f3;
        i_br_less     = lt;
        i_br_equal    = eq;
        i_target      = tgt;
        i_instr_ready = 1'b1;
        step();
        i_instr_ready = 1'b0;
        i_branch      = 1'b0;
        i_jump        = 1'b0;
        m_pc          = model_next(m_pc, br, jp, f3, lt, eq, tgt, m_mis);
        m_instret     = m_instret + 32'd1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        step();
        step();
        m_pc = RESET_PC; m_instret = 32'd0; m_instr = NOP_WORD; m_mis = 1'b0;
        n_cmp++; if (o_imem_req !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_req: got %b want 1", o_imem_req); end
        n_cmp++; if (o_imem_addr !== RESET_PC) begin n_fail++; $display("[TB] FAIL reset_addr: got %h want %h", o_imem_addr, RESET_PC); end
        n_cmp++; if (o_instr !== NOP_WORD) begin n_fail++; $display("[TB] FAIL reset_instr: got %h want %h", o_instr, NOP_WORD); end
        n_cmp++; if (o_instret !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_instret: got %0d want 0", o_instret); end
        n_cmp++; if (o_instr_valid !== 1'b0 || o_misaligned !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_flags: got valid=%b mis=%b want 0/0", o_instr_valid, o_misaligned); end
        i_rst = 1'b0;
    endtask

    task automatic test_basic_fetch();
        i_imem_ready = 1'b1;
        step();
        i_imem_ready = 1'b0;
        n_cmp++; if (o_imem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL wait_req: got %b want 0", o_imem_req); end
        i_imem_rvalid = 1'b1;
        i_imem_rdata  = 32'h0050_0093;
        step();
        i_imem_rvalid = 1'b0;
        n_cmp++; if (o_instr_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL hold_valid: got %b want 1", o_instr_valid); end
        n_cmp++; if (o_pc !== 32'd0) begin n_fail++; $display("[TB] FAIL hold_pc: got %h want 0", o_pc); end
        n_cmp++; if (o_instr !== 32'h0050_0093) begin n_fail++; $display("[TB] FAIL hold_instr: got %h want 00500093", o_instr); end
        do_accept(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
        n_cmp++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'd4) begin n_fail++; $display("[TB] FAIL seq_addr: got req=%b addr=%h want 1/00000004", o_imem_req, o_imem_addr); end
        n_cmp++; if (o_instret !== 32'd1) begin n_fail++; $display("[TB] FAIL seq_instret: got %0d want 1", o_instret); end
    endtask

    task automatic test_beq();
        do_fetch(32'h0000_006F);
        do_accept(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 32'h40);
        n_cmp++; if (o_imem_addr !== 32'h40) begin n_fail++; $display("[TB] FAIL jump_addr: got %h want 00000040", o_imem_addr); end
        do_fetch(32'h0000_0063);
        n_cmp++; if (o_pc !== 32'h40) begin n_fail++; $display("[TB] FAIL beq_pc: got %h want 00000040", o_pc); end
        do_accept(1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 32'h80);
        n_cmp++; if (o_imem_addr !== 32'h80) begin n_fail++; $display("[TB] FAIL beq_taken: got %h want 00000080", o_imem_addr); end
        do_fetch(32'h0000_006F);
        do_accept(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 32'h40);
        do_fetch(32'h0000_0063);
        do_accept(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 32'h80);
        n_cmp++; if (o_imem_addr !== 32'h44) begin n_fail++; $display("[TB] FAIL beq_not_taken: got %h want 00000044", o_imem_addr); end
        n_cmp++; if (o_instret !== m_instret) begin n_fail++; $display("[TB] FAIL beq_instret: got %0d want %0d", o_instret, m_instret); end
    endtask

    task automatic test_br_un();
        logic [2:0] f3;
        for (int k = 0; k < 8; k++) begin
            f3 = 3'(k);
            i_funct3 = f3;
            #1;
            n_cmp++; if (o_br_un !== f3[1]) begin n_fail++; $display("[TB] FAIL br_un f3=%0d: got %b want %b", k, o_br_un, f3[1]); end
        end
        do_fetch(32'h0000_6063);
        do_accept(1'b1, 1'b0, 3'b110, 1'b1, 1'b0, 32'h200);
        n_cmp++; if (o_imem_addr !== 32'h200) begin n_fail++; $display("[TB] FAIL bltu_taken: got %h want 00000200", o_imem_addr); end
        do_fetch(32'h0000_3063);
        do_accept(1'b1, 1'b0, 3'b011, 1'b1, 1'b0, 32'h300);
        n_cmp++; if (o_imem_addr !== 32'h204) begin n_fail++; $display("[TB] FAIL f3_011_not_taken: got %h want 00000204", o_imem_addr); end
    endtask

    task automatic test_misaligned();
        do_fetch(32'h0000_006F);
        do_accept(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 32'h103);
        n_cmp++; if (o_misaligned !== 1'b1) begin n_fail++; $display("[TB] FAIL mis_pulse: got %b want 1", o_misaligned); end
        n_cmp++; if (o_imem_addr !== TRAP_VEC) begin n_fail++; $display("[TB] FAIL mis_trap_addr: got %h want %h", o_imem_addr, TRAP_VEC); end
        step();
        n_cmp++; if (o_misaligned !== 1'b0) begin n_fail++; $display("[TB] FAIL mis_one_cycle: got %b want 0", o_misaligned); end
        do_fetch(32'h0000_006F);
        do_accept(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 32'h151);
        n_cmp++; if (o_misaligned !== 1'b0 || o_imem_addr !== 32'h150) begin n_fail++; $display("[TB] FAIL odd_target: got mis=%b addr=%h want 0/00000150", o_misaligned, o_imem_addr); end
    endtask

    task automatic test_stall_and_wrap();
        logic stable;
        do_fetch(32'h0000_006F);
        do_accept(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 32'hFFFF_FFFC);
        stable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            i_imem_rvalid = k[0];
            i_imem_rdata  = 32'hBAD0_0000 + 32'(k);
            step();
            if (o_imem_req !== 1'b1 || o_imem_addr !== 32'hFFFF_FFFC || o_instr_valid !== 1'b0) stable = 1'b0;
        end
        i_imem_rvalid = 1'b0;
        n_cmp++; if (stable !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_stable: got req=%b addr=%h want 1/fffffffc", o_imem_req, o_imem_addr); end
        do_fetch(32'h1234_5678);
        n_cmp++; if (o_instr !== 32'h1234_5678) begin n_fail++; $display("[TB] FAIL after_stall_instr: got %h want 12345678", o_instr); end
        i_imem_rvalid = 1'b1;
        i_imem_rdata  = 32'hDEAD_BEEF;
        step();
        i_imem_rvalid = 1'b0;
        n_cmp++; if (o_instr !== 32'h1234_5678 || o_instr_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL hold_rvalid_ignored: got %h want 12345678", o_instr); end
        do_accept(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
        n_cmp++; if (o_imem_addr !== 32'h0) begin n_fail++; $display("[TB] FAIL pc_wrap: got %h want 00000000", o_imem_addr); end
    endtask

    task automatic test_reset_in_wait();
        do_fetch(32'h0000_0013);
        do_accept(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 32'h0000_0800);
        i_imem_ready = 1'b1;
        step();
        i_imem_ready = 1'b0;
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        m_pc = RESET_PC; m_instret = 32'd0; m_instr = NOP_WORD;
        step();
        i_imem_rvalid = 1'b1;
        i_imem_rdata  = 32'hCAFE_F00D;
        step();
        i_imem_rvalid = 1'b0;
        n_cmp++; if (o_instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_wait_valid: got %b want 0", o_instr_valid); end
        n_cmp++; if (o_instr !== NOP_WORD) begin n_fail++; $display("[TB] FAIL rst_wait_instr: got %h want %h", o_instr, NOP_WORD); end
        n_cmp++; if (o_imem_req !== 1'b1 || o_imem_addr !== RESET_PC) begin n_fail++; $display("[TB] FAIL rst_wait_addr: got req=%b addr=%h want 1/%h", o_imem_req, o_imem_addr, RESET_PC); end
        n_cmp++; if (o_instret !== 32'd0) begin n_fail++; $display("[TB] FAIL rst_wait_instret: got %0d want 0", o_instret); end
    endtask

    task automatic test_random();
        logic [31:0] data;
        logic [31:0] tgt;
        logic [2:0]  f3;
        logic        br, jp, lt, eq;
        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                i_imem_rvalid = 1'($urandom);
                step();
            end
            i_imem_rvalid = 1'b0;
            n_cmp++; if (o_imem_req !== 1'b1 || o_imem_addr !== m_pc) begin n_fail++; $display("[TB] FAIL rnd_req #%0d: got req=%b addr=%h want 1/%h", n, o_imem_req, o_imem_addr, m_pc); end
            i_imem_ready = 1'b1;
            step();
            i_imem_ready = 1'b0;
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) step();
            n_cmp++; if (o_imem_req !== 1'b0 || o_instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rnd_wait #%0d: got req=%b valid=%b want 0/0", n, o_imem_req, o_instr_valid); end
            data          = $urandom;
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = data;
            step();
            i_imem_rvalid = 1'b0;
            m_instr       = data;
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                i_branch = 1'($urandom); i_jump = 1'($urandom); i_target = $urandom;
                i_imem_rvalid = 1'($urandom); i_imem_rdata = $urandom;
                step();
            end
            i_imem_rvalid = 1'b0;
            n_cmp++; if (o_instr_valid !== 1'b1 || o_pc !== m_pc || o_instr !== m_instr) begin n_fail++; $display("[TB] FAIL rnd_hold #%0d: got v=%b pc=%h instr=%h want 1/%h/%h", n, o_instr_valid, o_pc, o_instr, m_pc, m_instr); end
            br  = 1'($urandom);
            jp  = ($urandom_range(0, 3) == 0);
            f3  = 3'($urandom);
            lt  = 1'($urandom);
            eq  = 1'($urandom);
            tgt = $urandom;
            i_funct3 = f3;
            #1;
            n_cmp++; if (o_br_un !== f3[1]) begin n_fail++; $display("[TB] FAIL rnd_br_un #%0d: got %b want %b", n, o_br_un, f3[1]); end
            do_accept(br, jp, f3, lt, eq, tgt);
            n_cmp++; if (o_imem_addr !== m_pc || o_misaligned !== m_mis) begin n_fail++; $display("[TB] FAIL rnd_next #%0d: got addr=%h mis=%b want %h/%b", n, o_imem_addr, o_misaligned, m_pc, m_mis); end
            n_cmp++; if (o_instret !== m_instret) begin n_fail++; $display("[TB] FAIL rnd_instret #%0d: got %0d want %0d", n, o_instret, m_instret); end
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        n_cmp = 0; n_fail = 0;
        i_rst = 1'b1; i_imem_ready = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = 32'h0;
        i_instr_ready = 1'b0; i_branch = 1'b0; i_jump = 1'b0; i_funct3 = 3'd0;
        i_br_less = 1'b0; i_br_equal = 1'b0; i_target = 32'h0;
        m_pc = RESET_PC; m_instret = 32'd0; m_instr = NOP_WORD; m_mis = 1'b0;
        test_reset();
        test_basic_fetch();
        test_beq();
        test_br_un();
        test_misaligned();
        test_stall_and_wrap();
        test_reset_in_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
